// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit: FSM sequencing fetch/decode/execute/memory/
// write-back over a shared variable-latency memory, with a memory watchdog.
// Optional retired-instruction counter enabled by defining INSTR_CNT_EN;
// without it instr_cnt is tied to zero and no counter flops exist.
module mips_multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 illegal,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_ALUWB, S_IEXEC, S_BRANCH, S_JUMP, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Watchdog limit widened by one bit so (count + 1) never wraps.
  localparam logic [8:0] WD_LIMIT = 9'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wd, wd_nxt;
  logic [1:0] rdst_q;

  // The zero flag is consumed by the datapath, which ANDs it with pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  // R-type funct codes this controller executes (jr handled separately).
  function automatic logic rtype_ok(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // ALU operation for a supported R-type funct.
  function automatic logic [2:0] rtype_aluop(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // ALU operation for the immediate arithmetic group.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    return (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
  endfunction

  // A waiting memory cycle that is the last one the watchdog tolerates.
  logic wd_hit;
  assign wd_hit = (({1'b0, wd} + 9'd1) >= WD_LIMIT);

  // State register, watchdog and write-back destination latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FETCH;
      wd     <= '0;
      rdst_q <= 2'b00;
    end else begin
      state <= state_nxt;
      wd    <= wd_nxt;
      if (state == S_RTEXEC)     rdst_q <= 2'b01;
      else if (state == S_IEXEC) rdst_q <= 2'b00;
    end
  end

  // Next-state and control outputs; everything is forced low while in reset
  // so mem_req drops immediately when rst asserts mid-access.
  always_comb begin
    state_nxt     = state;
    wd_nxt        = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    fault         = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end else if (wd_hit) begin
            state_nxt = S_FAULT;
          end else begin
            wd_nxt = wd + 8'd1;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW:     state_nxt = S_MEMADR;
            OP_ADDI, OP_SLTI: state_nxt = S_IEXEC;
            OP_BEQ:           state_nxt = S_BRANCH;
            OP_J, OP_JAL:     state_nxt = S_JUMP;
            OP_RTYPE: begin
              if (func == FN_JR) begin
                state_nxt = S_JUMP;
              end else if (rtype_ok(func)) begin
                state_nxt = S_RTEXEC;
              end else begin
                illegal   = 1'b1;
                state_nxt = S_FETCH;
              end
            end
            default: begin
              illegal   = 1'b1;
              state_nxt = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = ALU_ADD;
          state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready)   state_nxt = S_MEMWB;
          else if (wd_hit) state_nxt = S_FAULT;
          else             wd_nxt    = wd + 8'd1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          reg_dst    = 2'b00;
          mem_to_reg = 2'b01;
          state_nxt  = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready)   state_nxt = S_FETCH;
          else if (wd_hit) state_nxt = S_FAULT;
          else             wd_nxt    = wd + 8'd1;
        end
        S_RTEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b00;
          alu_op    = rtype_aluop(func);
          state_nxt = S_ALUWB;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = imm_aluop(opcode);
          state_nxt = S_ALUWB;
        end
        S_ALUWB: begin
          // ALU setup is held from execute so its inputs stay stable
          // while ALUOut is written back.
          alu_src_a  = 1'b1;
          alu_src_b  = (opcode == OP_RTYPE) ? 2'b00 : 2'b10;
          alu_op     = (opcode == OP_RTYPE) ? rtype_aluop(func) : imm_aluop(opcode);
          reg_write  = 1'b1;
          reg_dst    = rdst_q;
          mem_to_reg = 2'b00;
          state_nxt  = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'b00;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          state_nxt     = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = (opcode == OP_RTYPE) ? 2'b11 : 2'b10;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          state_nxt = S_FETCH;
        end
        S_FAULT: begin
          fault = 1'b1;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

`ifdef INSTR_CNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign retire = (state_nxt == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                   (state == S_BRANCH) || (state == S_JUMP));

  // Retired-instruction counter, wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: per-cycle vector table plus
// hand-written sequences for memory timeout, acceptance on the last
// tolerated cycle, and asynchronous reset.
module tb_mips_multicycle_controller;

  localparam int TO = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, func;
  logic          zero, mem_ready;
  logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic          alu_src_a, reg_write, illegal, fault;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_cnt;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .fault(fault),
    .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       fault;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
    logic       retire;
  } vec_t;

  outs_t act;
  assign act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                reg_write, illegal, fault};

  int            total = 0;
  int            bad   = 0;
  int            vec_no = 0;
  logic [CW-1:0] cnt_model = '0;
  vec_t          tbl[$];

  outs_t X0, FW, FG, DEC, DIL, MA, MR, MWB, MW, BR, XJ, XJAL, XJR, FLT;

  function automatic outs_t rt(input logic [2:0] op);
    outs_t o;
    o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = op;
    return o;
  endfunction
  function automatic outs_t wbr(input logic [2:0] op);
    outs_t o;
    o = rt(op); o.reg_write = 1'b1; o.reg_dst = 2'b01;
    return o;
  endfunction
  function automatic outs_t ie(input logic [2:0] op);
    outs_t o;
    o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = op;
    return o;
  endfunction
  function automatic outs_t wbi(input logic [2:0] op);
    outs_t o;
    o = ie(op); o.reg_write = 1'b1; o.reg_dst = 2'b00;
    return o;
  endfunction

  function automatic logic [CW-1:0] want_cnt();
`ifdef INSTR_CNT_EN
    return cnt_model;
`else
    return '0;
`endif
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input outs_t e, input logic ret);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.retire = ret;
    tbl.push_back(v);
  endtask

  task automatic check_now(input outs_t e, input string tag);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s outputs got=%h want=%h", tag, act, e);
    end
    total++;
    if (instr_cnt !== want_cnt()) begin
      bad++;
      $display("FAIL %s instr_cnt got=%0d want=%0d", tag, instr_cnt, want_cnt());
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    opcode = v.op; func = v.fn; zero = v.z; mem_ready = v.rdy;
    @(negedge clk);
    check_now(v.exp, $sformatf("vec%0d", vec_no));
    vec_no++;
    if (v.retire) cnt_model = cnt_model + CW'(1);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input outs_t e, input logic ret);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.retire = ret;
    step(v);
  endtask

  initial begin
    X0 = '0;
    FW = '0; FW.mem_req = 1; FW.alu_src_b = 2'b01; FW.alu_op = 3'b010;
    FG = FW; FG.ir_write = 1; FG.pc_write = 1;
    DEC = '0; DEC.alu_src_b = 2'b11; DEC.alu_op = 3'b010;
    DIL = DEC; DIL.illegal = 1;
    MA = '0; MA.alu_src_a = 1; MA.alu_src_b = 2'b10; MA.alu_op = 3'b010;
    MR = '0; MR.mem_req = 1; MR.i_or_d = 1;
    MWB = '0; MWB.reg_write = 1; MWB.mem_to_reg = 2'b01;
    MW = '0; MW.mem_req = 1; MW.mem_we = 1; MW.i_or_d = 1;
    BR = '0; BR.alu_src_a = 1; BR.alu_src_b = 2'b00; BR.alu_op = 3'b110;
    BR.pc_write_cond = 1; BR.pc_src = 2'b01;
    XJ = '0; XJ.pc_write = 1; XJ.pc_src = 2'b10;
    XJAL = XJ; XJAL.reg_write = 1; XJAL.reg_dst = 2'b10; XJAL.mem_to_reg = 2'b10;
    XJR = '0; XJR.pc_write = 1; XJR.pc_src = 2'b11;
    FLT = '0; FLT.fault = 1;

    // add / addi / sub / slti / and / or / slt, memory answers at once
    add(6'h00, 6'h20, 0, 1, FG, 0); add(6'h00, 6'h20, 0, 1, DEC, 0);
    add(6'h00, 6'h20, 0, 1, rt(3'b010), 0); add(6'h00, 6'h20, 0, 1, wbr(3'b010), 1);
    add(6'h08, 6'h00, 0, 1, FG, 0); add(6'h08, 6'h00, 0, 1, DEC, 0);
    add(6'h08, 6'h00, 0, 1, ie(3'b010), 0); add(6'h08, 6'h00, 0, 1, wbi(3'b010), 1);
    add(6'h00, 6'h22, 0, 1, FG, 0); add(6'h00, 6'h22, 0, 1, DEC, 0);
    add(6'h00, 6'h22, 0, 1, rt(3'b110), 0); add(6'h00, 6'h22, 0, 1, wbr(3'b110), 1);
    add(6'h0a, 6'h00, 0, 1, FG, 0); add(6'h0a, 6'h00, 0, 1, DEC, 0);
    add(6'h0a, 6'h00, 0, 1, ie(3'b111), 0); add(6'h0a, 6'h00, 0, 1, wbi(3'b111), 1);
    add(6'h00, 6'h24, 0, 1, FG, 0); add(6'h00, 6'h24, 0, 1, DEC, 0);
    add(6'h00, 6'h24, 0, 1, rt(3'b000), 0); add(6'h00, 6'h24, 0, 1, wbr(3'b000), 1);
    add(6'h00, 6'h25, 0, 1, FG, 0); add(6'h00, 6'h25, 0, 1, DEC, 0);
    add(6'h00, 6'h25, 0, 1, rt(3'b001), 0); add(6'h00, 6'h25, 0, 1, wbr(3'b001), 1);
    add(6'h00, 6'h2a, 0, 1, FG, 0); add(6'h00, 6'h2a, 0, 1, DEC, 0);
    add(6'h00, 6'h2a, 0, 1, rt(3'b111), 0); add(6'h00, 6'h2a, 0, 1, wbr(3'b111), 1);
    // lw: fetch answers on 3rd cycle, read on 2nd; stray mem_ready elsewhere ignored
    add(6'h23, 6'h00, 0, 0, FW, 0); add(6'h23, 6'h00, 0, 0, FW, 0);
    add(6'h23, 6'h00, 0, 1, FG, 0); add(6'h23, 6'h00, 0, 1, DEC, 0);
    add(6'h23, 6'h00, 0, 1, MA, 0); add(6'h23, 6'h00, 0, 0, MR, 0);
    add(6'h23, 6'h00, 0, 1, MR, 0); add(6'h23, 6'h00, 0, 1, MWB, 1);
    // sw
    add(6'h2b, 6'h00, 0, 1, FG, 0); add(6'h2b, 6'h00, 0, 1, DEC, 0);
    add(6'h2b, 6'h00, 0, 1, MA, 0); add(6'h2b, 6'h00, 0, 1, MW, 1);
    // beq taken and not taken: controller outputs identical
    add(6'h04, 6'h00, 1, 1, FG, 0); add(6'h04, 6'h00, 1, 1, DEC, 0);
    add(6'h04, 6'h00, 1, 1, BR, 1);
    add(6'h04, 6'h00, 0, 1, FG, 0); add(6'h04, 6'h00, 0, 1, DEC, 0);
    add(6'h04, 6'h00, 0, 1, BR, 1);
    // j / jal / jr
    add(6'h02, 6'h00, 0, 1, FG, 0); add(6'h02, 6'h00, 0, 1, DEC, 0);
    add(6'h02, 6'h00, 0, 1, XJ, 1);
    add(6'h03, 6'h00, 0, 1, FG, 0); add(6'h03, 6'h00, 0, 1, DEC, 0);
    add(6'h03, 6'h00, 0, 1, XJAL, 1);
    add(6'h00, 6'h08, 0, 1, FG, 0); add(6'h00, 6'h08, 0, 1, DEC, 0);
    add(6'h00, 6'h08, 0, 1, XJR, 1);
    // illegal opcode, illegal funct: skipped, not counted
    add(6'h3f, 6'h00, 0, 1, FG, 0); add(6'h3f, 6'h00, 0, 1, DIL, 0);
    add(6'h00, 6'h3f, 0, 1, FG, 0); add(6'h00, 6'h3f, 0, 1, DIL, 0);
    // add again to show normal flow resumes
    add(6'h00, 6'h20, 0, 1, FG, 0); add(6'h00, 6'h20, 0, 1, DEC, 0);
    add(6'h00, 6'h20, 0, 1, rt(3'b010), 0); add(6'h00, 6'h20, 0, 1, wbr(3'b010), 1);

    // Reset: all outputs low even with mem_ready high
    rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_now(X0, "reset");
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_now(FW, "release");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // sw answered on the last tolerated cycle, then fetch answered on its 4th
    run(6'h2b, 6'h00, 0, 1, FG, 0); run(6'h2b, 6'h00, 0, 1, DEC, 0);
    run(6'h2b, 6'h00, 0, 1, MA, 0);
    run(6'h2b, 6'h00, 0, 0, MW, 0); run(6'h2b, 6'h00, 0, 0, MW, 0);
    run(6'h2b, 6'h00, 0, 0, MW, 0); run(6'h2b, 6'h00, 0, 1, MW, 1);
    run(6'h2b, 6'h00, 0, 0, FW, 0); run(6'h2b, 6'h00, 0, 0, FW, 0);
    run(6'h2b, 6'h00, 0, 0, FW, 0); run(6'h2b, 6'h00, 0, 1, FG, 0);
    // sw never answered: fault after 4 waiting cycles, sticky
    run(6'h2b, 6'h00, 0, 0, DEC, 0); run(6'h2b, 6'h00, 0, 0, MA, 0);
    run(6'h2b, 6'h00, 0, 0, MW, 0); run(6'h2b, 6'h00, 0, 0, MW, 0);
    run(6'h2b, 6'h00, 0, 0, MW, 0); run(6'h2b, 6'h00, 0, 0, MW, 0);
    run(6'h2b, 6'h00, 0, 0, FLT, 0); run(6'h2b, 6'h00, 0, 1, FLT, 0);
    run(6'h2b, 6'h00, 0, 1, FLT, 0);

    // Only reset leaves FAULT
    #2;
    rst = 1'b0; mem_ready = 1'b0;
    cnt_model = '0;
    #1;
    check_now(X0, "fault_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_now(FW, "fault_release");
    run(6'h00, 6'h00, 0, 0, FW, 0);

    // Reset mid-access drops mem_req without a clock edge
    #2;
    rst = 1'b0;
    #1;
    check_now(X0, "async_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_now(FW, "async_release");
    // Fetch never answered: release cycle is wait 1, fault after wait 4
    run(6'h00, 6'h00, 0, 0, FW, 0); run(6'h00, 6'h00, 0, 0, FW, 0);
    run(6'h00, 6'h00, 0, 0, FW, 0); run(6'h00, 6'h00, 0, 0, FLT, 0);
    run(6'h00, 6'h00, 0, 1, FLT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Control unit for the multi-cycle generation of the MIPS core. It replaces the single-cycle decoder with an explicit FSM that sequences fetch, decode, execute, memory and write-back over several cycles. Memory is shared between instruction and data and answers through a variable-latency req/ready handshake. A watchdog detects a hung memory. The datapath keeps PC, IR, A/B, ALUOut and MDR registers, driven by this block's enables.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay unanswered before FAULT; legal range 1..255.
CNT_WIDTH, 32, width of the retired-instruction counter (optional feature).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in BRANCH state
mem_ready  in  1  memory completion for the current mem_req
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
i_or_d  out  1  0 = address is PC, 1 = ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A (jr)
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (jal link)
reg_write  out  1  register file write
illegal  out  1  one-cycle pulse on an unsupported opcode/func
fault  out  1  sticky memory-timeout flag
instr_cnt  out  CNT_WIDTH  retired instructions (optional feature)

Behaviour:
- Reset (rst=0, async): state=FETCH, watchdog=0, fault=0, instr_cnt=0, every output 0 except FETCH Moore outputs, which become valid once rst releases.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, ALUWB, IEXEC, BRANCH, JUMP, FAULT.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010. On the edge where mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next DECODE. Otherwise stay in FETCH with no IR/PC enables.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=010 (branch target into ALUOut). Dispatch:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> RTEXEC; func jr (001000) -> JUMP
  - addi/slti (001000/001010) -> IEXEC
  - beq (000100) -> BRANCH
  - j/jal (000010/000011) -> JUMP
  - anything else -> illegal=1 for one cycle, then FETCH (instruction skipped, not counted)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=010; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, i_or_d=1; on mem_ready -> MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEMWR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready -> FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op from func (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> ALUWB with reg_dst=01.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op 010 (addi) or 111 (slti) -> ALUWB with reg_dst=00.
- ALUWB: reg_write=1, mem_to_reg=00, reg_dst latched from the prior state -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_src=01 -> FETCH.
- JUMP: pc_write=1. pc_src=10 for j/jal, 11 for jr. jal also asserts reg_write=1, reg_dst=10, mem_to_reg=10 (PC already +4) -> FETCH.
- Latencies: R/I-type 4 cycles, lw 5, sw 4, beq 3, j/jal/jr 3. Each memory state adds (cycles until mem_ready) - 1.
- Watchdog: counts cycles in any mem_req state without mem_ready. It clears on state entry and on mem_ready.
  - If mem_ready arrives on cycle MEM_TIMEOUT of the wait, it is accepted.
  - If the count reaches MEM_TIMEOUT with mem_ready low -> FAULT.
- FAULT: all enables and mem_req=0, fault=1. Exit only via reset.
- mem_ready outside a mem_req state is ignored.
- Reset mid-access drops mem_req asynchronously.

Optional Feature:
INSTR_CNT_EN: when defined, instr_cnt increments by 1 on every transition into FETCH from a completing state (MEMWB, MEMWR, ALUWB, BRANCH, JUMP), wrapping modulo 2^CNT_WIDTH. Illegal-skip and FAULT do not count. When undefined, instr_cnt is tied to 0 and no counter flops exist.

Test Plan:
- add R-type, mem_ready=1 immediately: FETCH->DECODE->RTEXEC->ALUWB->FETCH; alu_op=010, reg_dst=01, reg_write=1 in cycle 4; instr_cnt=1.
- lw, mem_ready delayed 3 cycles in FETCH and 2 in MEMRD: total 5+2+1=8 cycles; ir_write and pc_write pulse exactly once; mem_to_reg=01 in MEMWB.
- beq, zero=1 then zero=0: pc_write_cond=1, pc_src=01, alu_op=110 in cycle 3 both times; 3-cycle instruction.
- jal: JUMP cycle shows pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; jr shows pc_src=11 with reg_write=0.
- opcode 111111: illegal pulses 1 cycle in DECODE, returns to FETCH, instr_cnt unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in MEMWR: fault=1 after 4 waiting cycles, mem_req=0, stuck until rst=0. Repeat with mem_ready on cycle 4: store accepted, no fault.
